// File: rtl/cnn_tx_pkg.sv
// Shared types and constants for the CNN result UART transmitter.
// Parity support is compiled in with CNN_TX_PARITY_EN.
package cnn_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic UART_IDLE_LVL = 1'b1;
    localparam int   DATA_BITS     = 8;
    localparam int   BAUD_W        = 12;

endpackage

// File: rtl/cnn_tx_fifo.sv
// Small synchronous byte FIFO feeding the CNN result serializer.
// Pointers wrap naturally; count carries one extra bit for full/empty.
module cnn_tx_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/cnn_result_tx.sv
// UART 8N1 transmitter for CNN result bytes, fed through a small FIFO.
// Define CNN_TX_PARITY_EN to add an even-parity bit before the stop bit.
module cnn_result_tx
    import cnn_tx_pkg::*;
#(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    output logic       busy,
    output logic       full,
    output logic       ovf
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;
`ifdef CNN_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          empty;
    logic [7:0]    head;
    logic [CW-1:0] count;
    logic          bit_end;

    // A full FIFO still accepts a byte when the serializer pops that cycle.
    assign push  = trmt && (!fifo_full || pop);
    assign ovf_d = ovf_q || (trmt && fifo_full && !pop);

    cnn_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (tx_data),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (empty),
        .count_o (count)
    );

    assign bit_end = (baud_q == BAUD_W'(BAUD_DIV - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef CNN_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                tx_d   = UART_IDLE_LVL;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
`ifdef CNN_TX_PARITY_EN
                    par_d   = ^head;
`endif
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    tx_d    = shift_q[1];
                    if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef CNN_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = PARITY;
`else
                        tx_d    = UART_IDLE_LVL;
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef CNN_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    tx_d    = UART_IDLE_LVL;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    bit_d  = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
`ifdef CNN_TX_PARITY_EN
                        par_d   = ^head;
`endif
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = UART_IDLE_LVL;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                bit_d   = '0;
                tx_d    = UART_IDLE_LVL;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= UART_IDLE_LVL;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef CNN_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign TX      = tx_q;
    assign tx_done = (state_q == STOP) && bit_end;
    assign busy    = (state_q != IDLE) || (count != '0);
    assign full    = fifo_full;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_cnn_result_tx.sv
// Directed bench for cnn_result_tx at BAUD_DIV=4, FIFO_DEPTH=4.
// Frame length follows CNN_TX_PARITY_EN when it is defined.
module tb_cnn_result_tx;

    localparam int BD = 4;
`ifdef CNN_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FCLK = NB * BD;
    localparam int MAXC = 512;

    logic       clk;
    logic       rst_n;
    logic       trmt;
    logic [7:0] tx_data;
    logic       tx_line;
    logic       tx_done;
    logic       busy;
    logic       full;
    logic       ovf;

    int total;
    int bad;

    logic       sv  [MAXC];
    logic [7:0] sd  [MAXC];
    logic       rtx [MAXC];
    logic       rdn [MAXC];
    logic       rbs [MAXC];
    logic       rfl [MAXC];
    logic       rov [MAXC];

    cnn_result_tx #(
        .BAUD_DIV   (BD),
        .FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (tx_line),
        .tx_done (tx_done),
        .busy    (busy),
        .full    (full),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic fbit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef CNN_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic clear_stim();
        for (int k = 0; k < MAXC; k++) begin
            sv[k] = 1'b0;
            sd[k] = 8'h00;
        end
    endtask

    // rec[k] holds outputs one time unit after edge k (the clock after it).
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            trmt    = sv[k];
            tx_data = sd[k];
            @(posedge clk);
            #1;
            rtx[k] = tx_line;
            rdn[k] = tx_done;
            rbs[k] = busy;
            rfl[k] = full;
            rov[k] = ovf;
        end
        trmt = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        trmt    = 1'b0;
        tx_data = 8'h00;
        #12;
        total++;
        if (tx_line !== 1'b1) begin
            bad++; $display("FAIL reset_tx got=%b exp=1", tx_line);
        end
        total++;
        if (tx_done !== 1'b0) begin
            bad++; $display("FAIL reset_done got=%b exp=0", tx_done);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b exp=0", busy);
        end
        total++;
        if (full !== 1'b0) begin
            bad++; $display("FAIL reset_full got=%b exp=0", full);
        end
        total++;
        if (ovf !== 1'b0) begin
            bad++; $display("FAIL reset_ovf got=%b exp=0", ovf);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic e;
        clear_stim();
        sv[0] = 1'b1;
        sd[0] = 8'hA5;
        run(FCLK + 3);
        total++;
        if (rtx[0] !== 1'b1) begin
            bad++; $display("FAIL single_tx_e0 got=%b exp=1", rtx[0]);
        end
        total++;
        if (rbs[0] !== 1'b1) begin
            bad++; $display("FAIL single_busy_e0 got=%b exp=1", rbs[0]);
        end
        for (int c = 1; c <= FCLK; c++) begin
            e = fbit(8'hA5, (c - 1) / BD);
            total++;
            if (rtx[c] !== e) begin
                bad++; $display("FAIL single_tx c=%0d got=%b exp=%b", c, rtx[c], e);
            end
        end
        for (int c = 0; c < FCLK + 3; c++) begin
            e = (c == FCLK);
            total++;
            if (rdn[c] !== e) begin
                bad++; $display("FAIL single_done c=%0d got=%b exp=%b", c, rdn[c], e);
            end
        end
        total++;
        if (rbs[FCLK] !== 1'b1) begin
            bad++; $display("FAIL single_busy_last got=%b exp=1", rbs[FCLK]);
        end
        total++;
        if (rbs[FCLK+1] !== 1'b0) begin
            bad++; $display("FAIL single_busy_drop got=%b exp=0", rbs[FCLK+1]);
        end
    endtask

    task automatic test_back_to_back(input logic [7:0] b0, input logic [7:0] b1);
        logic e;
        logic [7:0] b;
        clear_stim();
        sv[0] = 1'b1; sd[0] = b0;
        sv[1] = 1'b1; sd[1] = b1;
        run(2 * FCLK + 3);
        for (int c = 1; c <= 2 * FCLK; c++) begin
            b = (c <= FCLK) ? b0 : b1;
            e = fbit(b, ((c - 1) % FCLK) / BD);
            total++;
            if (rtx[c] !== e) begin
                bad++; $display("FAIL b2b_tx c=%0d got=%b exp=%b", c, rtx[c], e);
            end
        end
        for (int c = 0; c < 2 * FCLK + 3; c++) begin
            e = (c == FCLK) || (c == 2 * FCLK);
            total++;
            if (rdn[c] !== e) begin
                bad++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, rdn[c], e);
            end
        end
        total++;
        if (rbs[FCLK+1] !== 1'b1) begin
            bad++; $display("FAIL b2b_busy_mid got=%b exp=1", rbs[FCLK+1]);
        end
        total++;
        if (rbs[2*FCLK+1] !== 1'b0) begin
            bad++; $display("FAIL b2b_busy_drop got=%b exp=0", rbs[2*FCLK+1]);
        end
    endtask

    task automatic test_parity();
        test_back_to_back(8'hA5, 8'h01);
`ifdef CNN_TX_PARITY_EN
        total++;
        if (rtx[9*BD+1] !== 1'b0) begin
            bad++; $display("FAIL parity_a5 got=%b exp=0", rtx[9*BD+1]);
        end
        total++;
        if (rtx[FCLK+9*BD+1] !== 1'b1) begin
            bad++; $display("FAIL parity_01 got=%b exp=1", rtx[FCLK+9*BD+1]);
        end
`endif
    endtask

    task automatic test_overflow();
        logic [7:0] bytes [6];
        logic e;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        clear_stim();
        for (int k = 0; k < 6; k++) begin
            sv[k] = 1'b1;
            sd[k] = bytes[k];
        end
        run(5 * FCLK + 3);
        total++;
        if (rfl[3] !== 1'b0) begin
            bad++; $display("FAIL ovf_full_e3 got=%b exp=0", rfl[3]);
        end
        total++;
        if (rfl[4] !== 1'b1) begin
            bad++; $display("FAIL ovf_full_e4 got=%b exp=1", rfl[4]);
        end
        total++;
        if (rov[4] !== 1'b0) begin
            bad++; $display("FAIL ovf_early got=%b exp=0", rov[4]);
        end
        total++;
        if (rov[5] !== 1'b1) begin
            bad++; $display("FAIL ovf_set got=%b exp=1", rov[5]);
        end
        total++;
        if (rov[5*FCLK+2] !== 1'b1) begin
            bad++; $display("FAIL ovf_sticky got=%b exp=1", rov[5*FCLK+2]);
        end
        for (int c = 1; c <= 5 * FCLK; c++) begin
            e = fbit(bytes[(c - 1) / FCLK], ((c - 1) % FCLK) / BD);
            total++;
            if (rtx[c] !== e) begin
                bad++; $display("FAIL ovf_tx c=%0d got=%b exp=%b", c, rtx[c], e);
            end
        end
        for (int c = 0; c < 5 * FCLK + 3; c++) begin
            e = (c != 0) && (c % FCLK == 0) && (c <= 5 * FCLK);
            total++;
            if (rdn[c] !== e) begin
                bad++; $display("FAIL ovf_done c=%0d got=%b exp=%b", c, rdn[c], e);
            end
        end
        total++;
        if (rbs[5*FCLK+1] !== 1'b0) begin
            bad++; $display("FAIL ovf_busy_drop got=%b exp=0", rbs[5*FCLK+1]);
        end
    endtask

    task automatic test_reset_mid();
        logic e;
        clear_stim();
        sv[0] = 1'b1;
        sd[0] = 8'h3C;
        run(14);
        total++;
        if (rtx[13] !== 1'b1) begin
            bad++; $display("FAIL mid_data_bit got=%b exp=1", rtx[13]);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (tx_line !== 1'b1) begin
            bad++; $display("FAIL mid_rst_tx got=%b exp=1", tx_line);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy);
        end
        total++;
        if (ovf !== 1'b0) begin
            bad++; $display("FAIL mid_rst_ovf got=%b exp=0", ovf);
        end
        total++;
        if (tx_done !== 1'b0) begin
            bad++; $display("FAIL mid_rst_done got=%b exp=0", tx_done);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_stim();
        run(FCLK + 3);
        for (int c = 0; c < FCLK + 3; c++) begin
            total++;
            if (rtx[c] !== 1'b1 || rdn[c] !== 1'b0) begin
                bad++; $display("FAIL mid_quiet c=%0d tx=%b done=%b exp tx=1 done=0", c, rtx[c], rdn[c]);
            end
        end
        clear_stim();
        sv[0] = 1'b1;
        sd[0] = 8'h96;
        run(FCLK + 3);
        for (int c = 1; c <= FCLK; c++) begin
            e = fbit(8'h96, (c - 1) / BD);
            total++;
            if (rtx[c] !== e) begin
                bad++; $display("FAIL mid_fresh_tx c=%0d got=%b exp=%b", c, rtx[c], e);
            end
        end
        total++;
        if (rdn[FCLK] !== 1'b1 || rdn[FCLK-1] !== 1'b0) begin
            bad++; $display("FAIL mid_fresh_done got=%b%b exp=01", rdn[FCLK-1], rdn[FCLK]);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_back_to_back(8'h00, 8'hFF);
        test_overflow();
        test_reset_mid();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
